// File: rtl/reaction_timer.sv
// Reaction-time game controller: 3-2-1 countdown, random blank wait, GO lamp,
// then millisecond measurement of the player's reaction with false-start and timeout faults.
module reaction_timer #(
    parameter int MS_PER_DIGIT = 1000,
    parameter int MIN_DELAY    = 4000,
    parameter int MAX_MS       = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1ms,
    input  logic        start,
    input  logic        react,
    input  logic [12:0] delay_ms,
    output logic [1:0]  digit,
    output logic        blank,
    output logic        go,
    output logic [13:0] reaction_ms,
    output logic        done,
    output logic        early,
    output logic        timeout,
    output logic [2:0]  dbg_state
);

    // start, react and tick_1ms are single-cycle pulses sampled on the rising edge;
    // there is no handshake: a pulse arriving in a state that does not use it is dropped.

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GO    = 3'd3,
        ST_DONE  = 3'd4,
        ST_EARLY = 3'd5,
        ST_TOUT  = 3'd6
    } state_t;

    localparam logic [12:0] DIGIT_LEN  = 13'(MS_PER_DIGIT);
    localparam logic [12:0] TWO_LEN    = 13'(2 * MS_PER_DIGIT);
    localparam logic [12:0] COUNT_LEN  = 13'(3 * MS_PER_DIGIT);
    localparam logic [12:0] DELAY_MIN  = 13'(MIN_DELAY);
    localparam logic [13:0] MS_LIMIT   = 14'(MAX_MS);

    state_t      state, state_n;
    logic [12:0] delay_q, delay_q_n;
    logic [12:0] ph, ph_n;
    logic [13:0] ms_cnt, ms_cnt_n;
    logic [1:0]  digit_n;
    logic        blank_n, go_n, done_n, early_n, timeout_n;
    logic [13:0] reaction_ms_n;

    logic [12:0] wait_len;
    logic [12:0] ph_inc;
    logic [13:0] ms_inc;

    // The floor on delay_q keeps this subtraction from wrapping.
    assign wait_len  = delay_q - COUNT_LEN;
    assign ph_inc    = ph + 13'd1;
    assign ms_inc    = ms_cnt + 14'd1;
    assign dbg_state = state;

    always_comb begin
        state_n       = state;
        delay_q_n     = delay_q;
        ph_n          = ph;
        ms_cnt_n      = ms_cnt;
        digit_n       = digit;
        blank_n       = blank;
        go_n          = go;
        reaction_ms_n = reaction_ms;
        done_n        = done;
        early_n       = early;
        timeout_n     = timeout;

        case (state)
            ST_IDLE, ST_DONE, ST_EARLY, ST_TOUT: begin
                if (start) begin
                    state_n       = ST_COUNT;
                    delay_q_n     = (delay_ms < DELAY_MIN) ? DELAY_MIN : delay_ms;
                    ph_n          = 13'd0;
                    ms_cnt_n      = 14'd0;
                    digit_n       = 2'd3;
                    blank_n       = 1'b0;
                    go_n          = 1'b0;
                    reaction_ms_n = 14'd0;
                    done_n        = 1'b0;
                    early_n       = 1'b0;
                    timeout_n     = 1'b0;
                end
            end

            ST_COUNT: begin
                if (react) begin
                    state_n       = ST_EARLY;
                    ph_n          = 13'd0;
                    digit_n       = 2'd0;
                    reaction_ms_n = 14'd0;
                    early_n       = 1'b1;
                end else if (tick_1ms) begin
                    if (ph_inc == COUNT_LEN) begin
                        state_n = ST_WAIT;
                        ph_n    = 13'd0;
                        digit_n = 2'd0;
                        blank_n = 1'b1;
                    end else begin
                        ph_n = ph_inc;
                        if (ph_inc < DIGIT_LEN)
                            digit_n = 2'd3;
                        else if (ph_inc < TWO_LEN)
                            digit_n = 2'd2;
                        else
                            digit_n = 2'd1;
                    end
                end
            end

            ST_WAIT: begin
                // react wins over the tick that would have ended the wait
                if (react) begin
                    state_n       = ST_EARLY;
                    ph_n          = 13'd0;
                    blank_n       = 1'b0;
                    reaction_ms_n = 14'd0;
                    early_n       = 1'b1;
                end else if (tick_1ms) begin
                    if (ph_inc == wait_len) begin
                        state_n  = ST_GO;
                        ph_n     = 13'd0;
                        ms_cnt_n = 14'd0;
                        blank_n  = 1'b0;
                        go_n     = 1'b1;
                    end else begin
                        ph_n = ph_inc;
                    end
                end
            end

            ST_GO: begin
                if (react) begin
                    state_n       = ST_DONE;
                    reaction_ms_n = ms_cnt;
                    go_n          = 1'b0;
                    done_n        = 1'b1;
                end else if (tick_1ms) begin
                    ms_cnt_n = ms_inc;
                    if (ms_inc == MS_LIMIT) begin
                        state_n       = ST_TOUT;
                        reaction_ms_n = MS_LIMIT;
                        go_n          = 1'b0;
                        timeout_n     = 1'b1;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            delay_q     <= 13'd0;
            ph          <= 13'd0;
            ms_cnt      <= 14'd0;
            digit       <= 2'd0;
            blank       <= 1'b0;
            go          <= 1'b0;
            reaction_ms <= 14'd0;
            done        <= 1'b0;
            early       <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            delay_q     <= delay_q_n;
            ph          <= ph_n;
            ms_cnt      <= ms_cnt_n;
            digit       <= digit_n;
            blank       <= blank_n;
            go          <= go_n;
            reaction_ms <= reaction_ms_n;
            done        <= done_n;
            early       <= early_n;
            timeout     <= timeout_n;
        end
    end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter MS_PER_DIGIT, default 1000, meaning ms each countdown digit is shown.
REQ-003 SHALL have parameter MIN_DELAY, default 4000, meaning the floor applied to the captured delay in ms.
REQ-004 SHALL have parameter MAX_MS, default 9999, meaning the reaction count saturation and timeout value.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst, input, 1, async active-high reset.
REQ-007 SHALL have port tick_1ms, input, 1, one-cycle strobe every 1 ms.
REQ-008 SHALL have port start, input, 1, debounced one-cycle start pulse.
REQ-009 SHALL have port react, input, 1, debounced one-cycle reaction pulse.
REQ-010 SHALL have port delay_ms, input, 13, pseudo-random total pre-GO delay in ms from the LFSR source.
REQ-011 SHALL have port digit, output, 2, countdown digit 3/2/1, or 0 when none.
REQ-012 SHALL have port blank, output, 1, display off during the random wait.
REQ-013 SHALL have port go, output, 1, GO lamp.
REQ-014 SHALL have port reaction_ms, output, 14, measured reaction time in ms.
REQ-015 SHALL have port done, output, 1, valid result held.
REQ-016 SHALL have port early, output, 1, false-start fault.
REQ-017 SHALL have port timeout, output, 1, no reaction within MAX_MS.

Function
REQ-018 SHALL implement the states IDLE, COUNT, WAIT, GO, DONE, EARLY and TOUT.
REQ-019 SHALL on start in IDLE, DONE, EARLY or TOUT move to COUNT on the next edge, with these actions:
- capture max(delay_ms, MIN_DELAY) into a 13-bit register;
- clear reaction_ms and all flags.
REQ-020 SHALL in COUNT drive digit 3, 2, then 1, each for MS_PER_DIGIT tick_1ms strobes, and enter WAIT on the 3*MS_PER_DIGIT-th tick.
REQ-021 SHALL in WAIT assert blank for (captured - 3*MS_PER_DIGIT) ticks, then enter GO.
REQ-022 SHALL count only on tick_1ms strobes; cycles without a strobe hold all counters.
REQ-023 SHALL in GO assert go and increment the 14-bit ms counter on each tick.
REQ-024 SHALL on react in GO latch the counter value before any same-cycle increment into reaction_ms, then enter DONE.
REQ-025 SHALL on react in COUNT or WAIT enter EARLY, with early=1 and reaction_ms=0.
REQ-026 SHALL in GO, on the tick that reaches MAX_MS without a react, enter TOUT with reaction_ms=MAX_MS and timeout=1.
REQ-027 SHALL resolve simultaneous react and final tick in WAIT as EARLY.
REQ-028 SHALL resolve simultaneous start and react in IDLE, DONE, EARLY or TOUT with start winning and react ignored.
REQ-029 SHALL ignore start while in COUNT, WAIT or GO.
REQ-030 SHALL ignore react while in IDLE, DONE, EARLY or TOUT.
REQ-031 SHALL hold done, early and timeout as levels until the next accepted start or reset.
REQ-032 SHALL drive all outputs from registers, combinationally independent of inputs.
REQ-033 SHALL compute the WAIT length in 13 bits, which cannot underflow because of the MIN_DELAY floor.

Reset
REQ-034 SHALL on rst assertion, at any time including mid-GO, immediately set these values:
- state IDLE;
- digit=0, blank=0, go=0;
- reaction_ms=0;
- done=0, early=0, timeout=0;
- all counters and the captured delay 0.
REQ-035 SHALL after rst deassertion remain in IDLE until a start pulse.

Verification
REQ-036 SHALL cover the normal run: delay_ms=5000, start, react 250 ticks after go rises -> digit 3,2,1 at 1000 ticks each, blank for 2000 ticks, then reaction_ms=250 and done=1.
REQ-037 SHALL cover the delay floor: delay_ms=100, start -> blank lasts exactly 1000 ticks.
REQ-038 SHALL cover the false start: react at tick 1500 of COUNT -> early=1, reaction_ms=0, go never asserted.
REQ-039 SHALL cover the timeout: no react -> after 9999 GO ticks timeout=1 and reaction_ms=9999.
REQ-040 SHALL cover the same-cycle react and tick in GO: react coincident with the tick taking the count 41->42 -> reaction_ms=41.
REQ-041 SHALL cover reset mid-GO: rst pulse at GO count 300 -> all outputs 0 and state IDLE; a following start begins a fresh COUNT at digit 3.
